// File: rtl/fc_pkg.sv
// Shared definitions for the FC-layer post-multiplier path: accumulator
// sizing, sign-magnitude to two's complement conversion and FSM states.
package fc_pkg;

    // FSM states of the accumulate/requantize controller
    localparam logic ACCUM = 1'b0;
    localparam logic OUT   = 1'b1;

    // Widest operand the conversion helper handles; callers size-cast down
    localparam int SM_MAX_W = 64;

    // Accumulator width: full product width plus growth for MAX_LEN terms
    function automatic int acc_width(input int data_width, input int max_len);
        return 2 * data_width + $clog2(max_len);
    endfunction

    // Sign-magnitude to two's complement; a negative zero comes out as 0
    function automatic logic [SM_MAX_W-1:0] sm_to_twos(input logic sign,
                                                       input logic [SM_MAX_W-1:0] mag);
        return sign ? (~mag + 1'b1) : mag;
    endfunction

endpackage

// File: rtl/fc_requant.sv
// Combinational requantizer: two's complement sum -> rounded, saturated,
// sign-magnitude activation. Shared by the FC and conv accumulation paths.
module fc_requant
    import fc_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 40,
    parameter int FRAC_SHIFT = 8,
    parameter int RELU       = 0
) (
    input  logic signed [ACC_WIDTH-1:0]  sum,
    output logic        [DATA_WIDTH-1:0] res_data,
    output logic                         res_sat
);

    // Largest magnitude representable in the output format
    localparam logic [ACC_WIDTH-1:0] MAX_MAG =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};

    logic                  sgn;
    logic [ACC_WIDTH-1:0]  mag;
    logic [ACC_WIDTH-1:0]  rnd;
    logic [DATA_WIDTH-2:0] mag_out;

    // The accumulator never reaches its most-negative value, so the
    // magnitude always fits in ACC_WIDTH bits.
    assign sgn = sum[ACC_WIDTH-1];
    assign mag = sgn ? (~unsigned'(sum) + 1'b1) : unsigned'(sum);

    // Rounding is half away from zero because it acts on the magnitude.
    // mag < 2^(ACC_WIDTH-1), so adding the half-LSB cannot overflow.
    generate
        if (FRAC_SHIFT == 0) begin : gen_noshift
            assign rnd = mag;
        end else begin : gen_shift
            localparam logic [ACC_WIDTH-1:0] HALF = ACC_WIDTH'(1) << (FRAC_SHIFT - 1);
            assign rnd = (mag + HALF) >> FRAC_SHIFT;
        end
    endgenerate

    // Saturate the magnitude, then suppress negative zero and (optionally)
    // negative results.
    always_comb begin
        res_sat  = 1'b0;
        mag_out  = rnd[DATA_WIDTH-2:0];
        res_data = '0;
        if (rnd > MAX_MAG) begin
            mag_out = '1;
            res_sat = 1'b1;
        end
        if ((rnd == '0) || ((RELU != 0) && sgn)) begin
            res_data = '0;
        end else begin
            res_data = {sgn, mag_out};
        end
    end

endmodule

// File: rtl/fc_accumulate_requant.sv
// FC-layer accumulator: sums one neuron's sign-magnitude products in two's
// complement, then emits a single requantized sign-magnitude activation.
module fc_accumulate_requant
    import fc_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int MAX_LEN    = 256,
    parameter int FRAC_SHIFT = 8,
    parameter int RELU       = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    prod_valid,
    output logic                    prod_ready,
    input  logic [2*DATA_WIDTH-1:0] prod_data,
    input  logic                    prod_last,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [DATA_WIDTH-1:0]   res_data,
    output logic                    res_sat,
    output logic                    len_err
);

    localparam int ACC_WIDTH = acc_width(DATA_WIDTH, MAX_LEN);
    localparam int PW        = 2 * DATA_WIDTH;
    localparam int CNT_W     = $clog2(MAX_LEN + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(MAX_LEN - 1);

    logic                        state_reg, state_next;
    logic signed [ACC_WIDTH-1:0] acc_reg;
    logic        [CNT_W-1:0]     cnt_reg;
    logic signed [ACC_WIDTH-1:0] term;
    logic signed [ACC_WIDTH-1:0] sum_next;
    logic                        prod_fire, res_fire, final_prod;
    logic [DATA_WIDTH-1:0]       rq_data;
    logic                        rq_sat;

    // Product converted to two's complement at accumulator width
    assign term = ACC_WIDTH'(sm_to_twos(prod_data[PW-1], SM_MAX_W'(prod_data[PW-2:0])));

    // The first term of a neuron overwrites whatever the previous neuron left
    assign sum_next = (cnt_reg == '0) ? term : (acc_reg + term);

    assign prod_fire  = prod_valid && prod_ready;
    assign res_fire   = res_valid && res_ready;
    assign final_prod = prod_fire && (prod_last || (cnt_reg == LAST_IDX));

    fc_requant #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH),
        .FRAC_SHIFT (FRAC_SHIFT),
        .RELU       (RELU)
    ) u_requant (
        .sum      (sum_next),
        .res_data (rq_data),
        .res_sat  (rq_sat)
    );

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ACCUM;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM next state: leave ACCUM on the closing product, OUT on result taken
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ACCUM:   if (final_prod) state_next = OUT;
            OUT:     if (res_fire)   state_next = ACCUM;
            default: state_next = ACCUM;
        endcase
    end

    // FSM outputs: products are only accepted while accumulating
    always_comb begin
        prod_ready = (state_reg == ACCUM);
    end

    // Accumulator, product counter, result registers and sticky length error
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_reg   <= '0;
            cnt_reg   <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_sat   <= 1'b0;
            len_err   <= 1'b0;
        end else begin
            if (prod_fire) begin
                acc_reg <= sum_next;
                cnt_reg <= cnt_reg + 1'b1;
            end
            if (final_prod) begin
                res_data  <= rq_data;
                res_sat   <= rq_sat;
                res_valid <= 1'b1;
                if (!prod_last) begin
                    len_err <= 1'b1;
                end
            end
            if (res_fire) begin
                res_valid <= 1'b0;
                cnt_reg   <= '0;
            end
        end
    end

endmodule

// File: tb/tb_fc_accumulate_requant.sv
// Directed-vector bench for fc_accumulate_requant (16-bit, 256 terms,
// shift 8); a second instance with RELU=1 covers negative suppression.
module tb_fc_accumulate_requant;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        prod_valid = 1'b0;
    logic        prod_ready;
    logic [31:0] prod_data  = '0;
    logic        prod_last  = 1'b0;
    logic        res_valid;
    logic        res_ready  = 1'b0;
    logic [15:0] res_data;
    logic        res_sat;
    logic        len_err;

    logic        r_prod_valid = 1'b0;
    logic        r_prod_ready;
    logic [31:0] r_prod_data  = '0;
    logic        r_prod_last  = 1'b0;
    logic        r_res_valid;
    logic        r_res_ready  = 1'b0;
    logic [15:0] r_res_data;
    logic        r_res_sat;
    logic        r_len_err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fc_accumulate_requant #(.DATA_WIDTH(16), .MAX_LEN(256), .FRAC_SHIFT(8), .RELU(0)) dut (
        .clk(clk), .rst(rst),
        .prod_valid(prod_valid), .prod_ready(prod_ready),
        .prod_data(prod_data), .prod_last(prod_last),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_sat(res_sat), .len_err(len_err)
    );

    fc_accumulate_requant #(.DATA_WIDTH(16), .MAX_LEN(256), .FRAC_SHIFT(8), .RELU(1)) dut_relu (
        .clk(clk), .rst(rst),
        .prod_valid(r_prod_valid), .prod_ready(r_prod_ready),
        .prod_data(r_prod_data), .prod_last(r_prod_last),
        .res_valid(r_res_valid), .res_ready(r_res_ready),
        .res_data(r_res_data), .res_sat(r_res_sat), .len_err(r_len_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Offer one product and return #1 after the edge it was accepted on
    task automatic send(input logic [31:0] d, input logic last);
        int n = 0;
        prod_valid = 1'b1;
        prod_data  = d;
        prod_last  = last;
        while (!prod_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("send_ready", prod_ready, 1);
        @(posedge clk); #1;
        prod_valid = 1'b0;
        prod_last  = 1'b0;
    endtask

    // Wait for, check and consume one result
    task automatic take(input string tag, input logic [15:0] exp_d, input logic exp_s);
        int n = 0;
        while (!res_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_valid"}, res_valid, 1);
        chk({tag, "_data"}, res_data, exp_d);
        chk({tag, "_sat"}, res_sat, exp_s);
        $display("txn %s res_data=%h res_sat=%b (want %h/%b)", tag, res_data, res_sat, exp_d, exp_s);
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        chk({tag, "_drop"}, res_valid, 0);
        chk({tag, "_pready"}, prod_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pready", prod_ready, 1);
        chk("rst_valid", res_valid, 0);
        chk("rst_data", res_data, 0);
        chk("rst_sat", res_sat, 0);
        chk("rst_lenerr", len_err, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Single product, result one cycle after the handshake
        send(32'h0000_0200, 1'b1);
        chk("lat_valid", res_valid, 1);
        chk("lat_pready", prod_ready, 0);
        take("single", 16'h0002, 1'b0);

        // Mixed signs: 1000 - 300 = 700 -> 3
        send(32'h0000_03E8, 1'b0);
        send(32'h8000_012C, 1'b1);
        take("mixed_pos", 16'h0003, 1'b0);
        send(32'h8000_03E8, 1'b0);
        send(32'h0000_012C, 1'b1);
        take("mixed_neg", 16'h8003, 1'b0);

        // Saturation both directions
        send(32'h2000_0000, 1'b0);
        send(32'h2000_0000, 1'b1);
        take("sat_pos", 16'h7FFF, 1'b1);
        send(32'hA000_0000, 1'b0);
        send(32'hA000_0000, 1'b1);
        take("sat_neg", 16'hFFFF, 1'b1);

        // Rounding to zero, no negative zero, half-way cases
        send(32'h0000_007F, 1'b1);
        take("rz_pos", 16'h0000, 1'b0);
        send(32'h8000_007F, 1'b1);
        take("rz_neg", 16'h0000, 1'b0);
        send(32'h0000_0180, 1'b1);
        take("half_pos", 16'h0002, 1'b0);
        send(32'h8000_0180, 1'b1);
        take("half_neg", 16'h8002, 1'b0);
        send(32'h0000_017F, 1'b1);
        take("below_half", 16'h0001, 1'b0);

        // Backpressure: result held, no products accepted
        send(32'h0000_0300, 1'b1);
        prod_valid = 1'b1;
        prod_data  = 32'h0000_7000;
        prod_last  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk("bp_valid", res_valid, 1);
            chk("bp_data", res_data, 16'h0003);
            chk("bp_pready", prod_ready, 0);
            @(posedge clk); #1;
        end
        prod_valid = 1'b0;
        prod_last  = 1'b0;
        take("bp_release", 16'h0003, 1'b0);

        // Forced termination at MAX_LEN: 256 * 256 = 65536 -> 256
        for (int i = 0; i < 256; i++) begin
            send(32'h0000_0100, 1'b0);
        end
        chk("len_err_set", len_err, 1);
        take("forced", 16'h0100, 1'b0);
        send(32'h0000_0200, 1'b1);
        chk("len_err_sticky", len_err, 1);
        take("after_forced", 16'h0002, 1'b0);

        // Reset in the middle of a vector discards the partial sum
        send(32'h0000_1000, 1'b0);
        send(32'h0000_1000, 1'b0);
        send(32'h0000_1000, 1'b0);
        rst = 1'b1;
        #2;
        chk("mid_rst_pready", prod_ready, 1);
        chk("mid_rst_valid", res_valid, 0);
        chk("mid_rst_data", res_data, 0);
        chk("mid_rst_sat", res_sat, 0);
        chk("mid_rst_lenerr", len_err, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        send(32'h0000_0200, 1'b1);
        take("post_rst", 16'h0002, 1'b0);

        // RELU instance: negative result clamps to +0, positive passes
        r_prod_valid = 1'b1;
        r_prod_data  = 32'h8000_03E8;
        r_prod_last  = 1'b1;
        chk("relu_pready", r_prod_ready, 1);
        @(posedge clk); #1;
        r_prod_valid = 1'b0;
        chk("relu_neg_valid", r_res_valid, 1);
        chk("relu_neg_data", r_res_data, 16'h0000);
        chk("relu_neg_sat", r_res_sat, 0);
        $display("txn relu_neg res_data=%h res_sat=%b (want 0000/0)", r_res_data, r_res_sat);
        r_res_ready = 1'b1;
        @(posedge clk); #1;
        r_res_ready = 1'b0;
        chk("relu_drop", r_res_valid, 0);
        r_prod_valid = 1'b1;
        r_prod_data  = 32'h0000_0200;
        @(posedge clk); #1;
        r_prod_valid = 1'b0;
        r_prod_last  = 1'b0;
        chk("relu_pos_valid", r_res_valid, 1);
        chk("relu_pos_data", r_res_data, 16'h0002);
        $display("txn relu_pos res_data=%h res_sat=%b (want 0002/0)", r_res_data, r_res_sat);
        r_res_ready = 1'b1;
        @(posedge clk); #1;
        r_res_ready = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
